// File: rtl/phys_reg_pkg.sv
// Shared rename-path constants: physical register count, data width, index width,
// plus the bit offset of a physical register inside the flattened read bus.
package phys_reg_pkg;

    localparam int NUM_PHYS_REGS = 64;
    localparam int DATA_W        = 32;
    localparam int PREG_IDX_W    = 6;

    function automatic int unsigned preg_lsb(input int unsigned idx, input int unsigned width = DATA_W);
        return idx * width;
    endfunction

endpackage

// File: rtl/phys_reg.sv
// Physical register file: one synchronous write port, whole array exposed combinationally.
// Write-to-visible latency is 1 clock, with no bypass; there is no backpressure, and stall simply drops the write.
module phys_reg
    import phys_reg_pkg::preg_lsb;
#(
    parameter int NUM_REGS = phys_reg_pkg::NUM_PHYS_REGS,
    parameter int DATA_W   = phys_reg_pkg::DATA_W,
    parameter int IDX_W    = phys_reg_pkg::PREG_IDX_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [IDX_W-1:0]           reg_to_update,
    input  logic [DATA_W-1:0]          new_value,
    input  logic                       update,
    output logic [NUM_REGS*DATA_W-1:0] regs
);

    logic wr_qual;
    assign wr_qual = update & ~stall;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == 0) begin : g_zero
            // Backs architectural $zero: no storage, writes fall on the floor.
            assign regs[preg_lsb(i, DATA_W) +: DATA_W] = '0;
        end else begin : g_flop
            logic              wr_en;
            logic [DATA_W-1:0] val_q;

            assign wr_en = wr_qual & (reg_to_update == IDX_W'(i));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    val_q <= '0;
                end else if (wr_en) begin
                    val_q <= new_value;
                end
            end

            assign regs[preg_lsb(i, DATA_W) +: DATA_W] = val_q;
        end
    end

endmodule

// File: tb/tb_phys_reg.sv
// Bench for phys_reg: directed scenarios plus random writes against an array model.
module tb_phys_reg;

    localparam int N  = 64;
    localparam int W  = 32;
    localparam int IW = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic [IW-1:0]   reg_to_update;
    logic [W-1:0]    new_value;
    logic            update;
    logic [N*W-1:0]  regs;

    int tests_run = 0;
    int tests_failed = 0;
    logic [W-1:0] model [N];

    phys_reg dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .reg_to_update (reg_to_update),
        .new_value     (new_value),
        .update        (update),
        .regs          (regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] slice(input int i);
        return regs[i*W +: W];
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s[%0d]", tag, i), slice(i), model[i]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) model[i] = '0;
    endtask

    // Presents one write for one edge; the target slice must still hold its old value before the edge.
    task automatic write(input string tag, input bit upd, input bit stl,
                         input logic [IW-1:0] idx, input logic [W-1:0] val, input bit full);
        update        = upd;
        stall         = stl;
        reg_to_update = idx;
        new_value     = val;
        #1;
        check($sformatf("%s_pre[%0d]", tag, idx), slice(int'(idx)), model[idx]);
        @(posedge clk);
        #1;
        if (!reset && upd && !stl && idx != 0) model[idx] = val;
        update = 1'b0;
        stall  = 1'b0;
        if (full) check_all(tag);
        else check($sformatf("%s[%0d]", tag, idx), slice(int'(idx)), model[idx]);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; update = 1'b0;
        reg_to_update = '0; new_value = '0;
        clear_model();

        // Async reset before any clock edge.
        #2 reset = 1'b1;
        #1 check_all("rst_async");

        // Writes are ignored while reset is held across an edge.
        write("rst_hold", 1'b1, 1'b0, 6'd9, 32'hCAFEF00D, 1'b1);
        reset = 1'b0;
        #1 check_all("rst_release");

        write("basic",   1'b1, 1'b0, 6'd5,  32'hDEADBEEF, 1'b1);
        write("stall",   1'b1, 1'b1, 6'd7,  32'h12345678, 1'b1);
        write("noupd",   1'b0, 1'b0, 6'd7,  32'h12345678, 1'b1);
        write("enable",  1'b1, 1'b0, 6'd7,  32'h12345678, 1'b1);
        write("zero",    1'b1, 1'b0, 6'd0,  32'hFFFFFFFF, 1'b1);
        write("top",     1'b1, 1'b0, 6'd63, 32'hA5A5A5A5, 1'b1);
        write("b2b_a",   1'b1, 1'b0, 6'd10, 32'h1,        1'b1);
        write("b2b_b",   1'b1, 1'b0, 6'd10, 32'h2,        1'b1);
        write("inter",   1'b1, 1'b0, 6'd11, 32'h3,        1'b1);

        for (int i = 1; i < N; i++)
            write("fill", 1'b1, 1'b0, IW'(i), W'(i), 1'b0);
        check_all("fill_all");

        // Reset pulse between clock edges.
        reset = 1'b1;
        #1 clear_model();
        check_all("rst_mid");
        reset = 1'b0;
        #1 check_all("rst_mid_rel");
        write("post_rst", 1'b1, 1'b0, 6'd3, 32'h33, 1'b1);

        for (int c = 0; c < 300; c++) begin
            write("rand",
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  IW'($urandom_range(0, N - 1)),
                  W'($urandom),
                  1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
